// File: rtl/qa_driver_sreg_sequencer.sv
// Services host SREG read requests: forwards each to one status source, waits for
// its response (or a timeout) and writes one result line into the DSM response slot.
module qa_driver_sreg_sequencer #(
    parameter int N_SRC          = 4,
    parameter int SREG_ADDR_BITS = 8,
    parameter int SRC_TIMEOUT    = 255,
    parameter int DSM_RSP_LINE   = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [63:0]               dsm_base,
    input  logic                      dsm_base_valid,
    input  logic                      sreg_req_en,
    input  logic [SREG_ADDR_BITS-1:0] sreg_req_addr,
    output logic [N_SRC-1:0]          src_req_valid,
    output logic [SREG_ADDR_BITS-1:0] src_req_addr,
    input  logic [N_SRC-1:0]          src_rsp_valid,
    input  logic [64*N_SRC-1:0]       src_rsp_data,
    output logic                      wr_valid,
    output logic [63:0]               wr_addr,
    output logic [127:0]              wr_data,
    input  logic                      wr_almost_full,
    output logic                      busy,
    output logic [15:0]               dropped_cnt
);

    localparam int SEL_W = $clog2(N_SRC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

    state_t                    state_q, state_d;
    logic [SREG_ADDR_BITS-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [63:0]               data_q, data_d;
    logic                      tmo_q, tmo_d;
    logic [31:0]               seq_q, seq_d;
    logic [15:0]               drop_q, drop_d;
    logic [16:0]               cnt_inc;
    logic                      drop_evt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
        end
    end

    // Payload registers are only observed through state-gated outputs, so no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        sel_q  <= sel_d;
        data_q <= data_d;
        tmo_q  <= tmo_d;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        tmo_d         = tmo_q;
        seq_d         = seq_q;
        drop_d        = drop_q;
        src_req_valid = '0;
        wr_valid      = 1'b0;
        drop_evt      = 1'b0;
        cnt_inc       = {1'b0, cnt_q} + 17'd1;

        case (state_q)
            S_IDLE: begin
                if (sreg_req_en) begin
                    if (dsm_base_valid) begin
                        addr_d  = sreg_req_addr;
                        sel_d   = sreg_req_addr[SREG_ADDR_BITS-1 -: SEL_W];
                        state_d = S_REQ;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                src_req_valid[sel_q] = 1'b1;
                cnt_d                = '0;
                state_d              = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the final waiting cycle takes priority over the timeout.
                if (src_rsp_valid[sel_q]) begin
                    data_d  = src_rsp_data[64*sel_q +: 64];
                    tmo_d   = 1'b0;
                    state_d = S_WRITE;
                end else if (cnt_inc == 17'(SRC_TIMEOUT)) begin
                    data_d  = '1;
                    tmo_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            S_WRITE: begin
                if (!wr_almost_full) begin
                    wr_valid = 1'b1;
                    seq_d    = seq_q + 32'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sreg_req_en && (state_q != S_IDLE)) begin
            drop_evt = 1'b1;
        end
        if (drop_evt && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    assign src_req_addr = ((state_q == S_REQ) || (state_q == S_WAIT)) ? addr_q : '0;
    assign wr_addr      = wr_valid ? (dsm_base + 64'(DSM_RSP_LINE)) : 64'd0;
    assign wr_data      = wr_valid ? {1'b1, tmo_q, 14'd0, 16'(addr_q), seq_q, data_q} : 128'd0;
    assign busy         = (state_q != S_IDLE);
    assign dropped_cnt  = drop_q;

endmodule

// File: tb/tb_qa_driver_sreg_sequencer.sv
// Directed bench for qa_driver_sreg_sequencer: request routing, timeout, drops,
// back-pressure, response filtering and mid-operation reset.
module tb_qa_driver_sreg_sequencer;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [63:0]   dsm_base;
    logic          dsm_base_valid;
    logic          sreg_req_en;
    logic [7:0]    sreg_req_addr;
    logic [3:0]    src_req_valid;
    logic [7:0]    src_req_addr;
    logic [3:0]    src_rsp_valid;
    logic [255:0]  src_rsp_data;
    logic          wr_valid;
    logic [63:0]   wr_addr;
    logic [127:0]  wr_data;
    logic          wr_almost_full;
    logic          busy;
    logic [15:0]   dropped_cnt;

    int n_chk = 0;
    int n_bad = 0;

    qa_driver_sreg_sequencer #(
        .N_SRC(4), .SREG_ADDR_BITS(8), .SRC_TIMEOUT(255), .DSM_RSP_LINE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dsm_base(dsm_base), .dsm_base_valid(dsm_base_valid),
        .sreg_req_en(sreg_req_en), .sreg_req_addr(sreg_req_addr),
        .src_req_valid(src_req_valid), .src_req_addr(src_req_addr),
        .src_rsp_valid(src_rsp_valid), .src_rsp_data(src_rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_almost_full(wr_almost_full), .busy(busy), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input int src, input logic [63:0] d);
        src_rsp_valid      = '0;
        src_rsp_valid[src] = 1'b1;
        src_rsp_data       = '0;
        src_rsp_data[64*src +: 64] = d;
    endtask

    task automatic rsp_clr();
        src_rsp_valid = '0;
        src_rsp_data  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        dsm_base       = '0;
        dsm_base_valid = 1'b0;
        sreg_req_en    = 1'b0;
        sreg_req_addr  = '0;
        wr_almost_full = 1'b0;
        rsp_clr();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_drop", dropped_cnt, 0);
        chk("rst_wrv", wr_valid, 0);
        chk("rst_srv", src_req_valid, 0);
        chk("rst_wrd", wr_data, 0);
        reset_n = 1'b1;

        // Basic request to source 1, response at cycle 3, write at cycle 4
        dsm_base = 64'h1000; dsm_base_valid = 1'b1;
        sreg_req_en = 1'b1; sreg_req_addr = 8'h41;
        tick();
        sreg_req_en = 1'b0;
        chk("t1_srv", src_req_valid, 4'b0010);
        chk("t1_sra", src_req_addr, 8'h41);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_srv_once", src_req_valid, 0);
        chk("t1_wrv_c2", wr_valid, 0);
        tick();
        rsp(1, 64'hDEADBEEF_00000001);
        chk("t1_wrv_c3", wr_valid, 0);
        tick();
        rsp_clr();
        chk("t1_wrv", wr_valid, 1);
        chk("t1_wra", wr_addr, 64'h1001);
        chk("t1_wrd", wr_data, {1'b1, 1'b0, 14'd0, 16'h0041, 32'd0, 64'hDEADBEEF_00000001});
        tick();
        chk("t1_wrv_end", wr_valid, 0);
        chk("t1_idle", busy, 0);
        chk("t1_wra_idle", wr_addr, 0);

        // Timeout on source 3: WAIT lasts 255 cycles, write at cycle 257
        sreg_req_en = 1'b1; sreg_req_addr = 8'hC0;
        tick();
        sreg_req_en = 1'b0;
        chk("t2_srv", src_req_valid, 4'b1000);
        tick();
        chk("t2_sra_wait", src_req_addr, 8'hC0);
        n = 2;
        while (!wr_valid && n < 400) begin
            tick();
            n++;
        end
        chk("t2_cycle", n, 257);
        chk("t2_wrd", wr_data, {1'b1, 1'b1, 14'd0, 16'h00C0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        tick();
        repeat (9) tick();
        rsp(3, 64'h77);
        tick();
        rsp_clr();
        chk("t2_late_wrv", wr_valid, 0);
        chk("t2_late_busy", busy, 0);
        tick();
        chk("t2_late_wrv2", wr_valid, 0);

        // Drop while base invalid, then drop while busy in WAIT and on the WRITE cycle
        dsm_base_valid = 1'b0;
        sreg_req_en = 1'b1; sreg_req_addr = 8'h00;
        tick();
        sreg_req_en = 1'b0;
        chk("t3_srv_drop", src_req_valid, 0);
        chk("t3_busy_drop", busy, 0);
        chk("t3_drop1", dropped_cnt, 1);
        dsm_base_valid = 1'b1;
        sreg_req_en = 1'b1;
        tick();
        sreg_req_en = 1'b0;
        chk("t3_srv", src_req_valid, 4'b0001);
        tick();
        sreg_req_en = 1'b1; sreg_req_addr = 8'h80;
        tick();
        sreg_req_en = 1'b0;
        chk("t3_drop2", dropped_cnt, 2);
        chk("t3_busy", busy, 1);
        chk("t3_sra_held", src_req_addr, 8'h00);
        rsp(0, 64'h1234);
        tick();
        rsp_clr();
        chk("t3_wrv", wr_valid, 1);
        chk("t3_wrd", wr_data, {1'b1, 1'b0, 14'd0, 16'h0000, 32'd2, 64'h1234});
        sreg_req_en = 1'b1; sreg_req_addr = 8'h40;
        tick();
        sreg_req_en = 1'b0;
        chk("t3_drop3", dropped_cnt, 3);
        chk("t3_busy_end", busy, 0);
        chk("t3_srv_none", src_req_valid, 0);

        // Back-pressure holds WRITE for 20 cycles
        wr_almost_full = 1'b1;
        sreg_req_en = 1'b1; sreg_req_addr = 8'h40;
        tick();
        sreg_req_en = 1'b0;
        tick();
        rsp(1, 64'hA5);
        tick();
        rsp_clr();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4_hold_wrv%0d", i), wr_valid, 0);
            chk($sformatf("t4_hold_busy%0d", i), busy, 1);
            tick();
        end
        wr_almost_full = 1'b0;
        #1;
        chk("t4_wrv", wr_valid, 1);
        chk("t4_wrd", wr_data, {1'b1, 1'b0, 14'd0, 16'h0040, 32'd3, 64'hA5});
        tick();
        chk("t4_single", wr_valid, 0);
        chk("t4_idle", busy, 0);

        // Non-selected strobe ignored; response on the timeout cycle wins
        sreg_req_en = 1'b1; sreg_req_addr = 8'h00;
        tick();
        sreg_req_en = 1'b0;
        tick();
        rsp(2, 64'h9999);
        tick();
        rsp_clr();
        chk("t5_other_wrv", wr_valid, 0);
        chk("t5_other_busy", busy, 1);
        repeat (253) tick();
        rsp(0, 64'h5555);
        chk("t5_pre_wrv", wr_valid, 0);
        tick();
        rsp_clr();
        chk("t5_wrv", wr_valid, 1);
        chk("t5_wrd", wr_data, {1'b1, 1'b0, 14'd0, 16'h0000, 32'd4, 64'h5555});
        tick();

        // Reset during WAIT aborts the request and clears seq and drop count
        sreg_req_en = 1'b1; sreg_req_addr = 8'h41;
        tick();
        sreg_req_en = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_drop", dropped_cnt, 0);
        chk("t6_srv", src_req_valid, 0);
        rsp(1, 64'hBAD);
        tick();
        rsp_clr();
        chk("t6_late_wrv", wr_valid, 0);
        chk("t6_late_busy", busy, 0);
        sreg_req_en = 1'b1; sreg_req_addr = 8'h42;
        tick();
        sreg_req_en = 1'b0;
        chk("t6_srv_new", src_req_valid, 4'b0010);
        tick();
        rsp(1, 64'hCAFE);
        tick();
        rsp_clr();
        chk("t6_wrv", wr_valid, 1);
        chk("t6_wrd", wr_data, {1'b1, 1'b0, 14'd0, 16'h0042, 32'd0, 64'hCAFE});
        tick();
        chk("t6_end", wr_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/qa_driver_sreg_sequencer.md
Name: qa_driver_sreg_sequencer

Overview:
- Services host status-register (SREG) read requests decoded from CSR writes: one-cycle request pulse carrying an SREG address.
- Routes each request to one of N_SRC status sources and waits for its response, with a timeout.
- Writes the result as one line into the DSM response slot through the shared write channel, honouring almost-full back-pressure.
- Sits between the CSR write decoder and the driver's DSM write path; handles one request at a time.

Parameters:
N_SRC, 4, number of status sources; power of two, >= 2; source index = sreg_req_addr[SREG_ADDR_BITS-1 -: log2(N_SRC)]
SREG_ADDR_BITS, 8, SREG address width
SRC_TIMEOUT, 255, max cycles in WAIT before forced completion; 1..65535
DSM_RSP_LINE, 1, line offset of response slot from DSM base

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
dsm_base  in  64  DSM base, line address
dsm_base_valid  in  1  DSM base programmed
sreg_req_en  in  1  one-cycle request pulse
sreg_req_addr  in  SREG_ADDR_BITS  requested SREG address
src_req_valid  out  N_SRC  one-hot request strobe to the selected source
src_req_addr  out  SREG_ADDR_BITS  address forwarded to sources
src_rsp_valid  in  N_SRC  per-source response strobe
src_rsp_data  in  64*N_SRC  per-source data; source i at [64*i +: 64]
wr_valid  out  1  DSM write strobe
wr_addr  out  64  DSM write line address
wr_data  out  128  DSM write line
wr_almost_full  in  1  write channel back-pressure
busy  out  1  FSM not in IDLE
dropped_cnt  out  16  saturating count of dropped requests

Behaviour:
- Clock and reset: reset_n is synchronous, active-low; clock is clk. All state is registered on posedge clk.
- Reset values: FSM=IDLE; all outputs 0; internal seq=0; timeout counter=0.
  - Reset asserted mid-operation aborts immediately.
  - No wr_valid is issued for the aborted request.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - sreg_req_en=1 and dsm_base_valid=1: latch addr and source index sel; go to REQ.
  - sreg_req_en=1 and dsm_base_valid=0: drop the request, dropped_cnt+1 (saturating at 16'hFFFF); stay in IDLE.
- REQ:
  - src_req_valid = 1<<sel for exactly one cycle; src_req_addr = latched addr (held through WAIT).
  - Clear timeout counter; go to WAIT.
- WAIT:
  - src_rsp_valid[sel]=1: capture data for sel; status=0; go to WRITE.
  - Otherwise, once the counter reaches SRC_TIMEOUT: data=64'hFFFF_FFFF_FFFF_FFFF, status timeout=1; go to WRITE.
  - A response in the same cycle as the timeout wins: no timeout is flagged.
  - Strobes from non-selected sources are ignored.
  - Late responses after leaving WAIT are ignored.
- WRITE:
  - wr_almost_full=0: wr_valid=1 for one cycle, seq+1 (wraps at 2^32), go to IDLE.
  - wr_almost_full=1: wr_valid=0; hold in WRITE indefinitely. No timeout applies here.
- wr_addr and wr_data are valid only while wr_valid=1 and are 0 otherwise.
  - wr_addr = dsm_base + DSM_RSP_LINE, sampled in the cycle wr_valid is driven; 64-bit add, wraps.
- wr_data layout:
  - [63:0] data
  - [95:64] seq, value before increment
  - [111:96] addr zero-extended
  - [125:112] 0
  - [126] timeout flag
  - [127] 1 (valid marker)
- Overlap:
  - sreg_req_en while FSM != IDLE: request dropped, dropped_cnt+1.
  - This includes a pulse in the same cycle WRITE completes; no queueing.
- busy = (state != IDLE).
- Latency: request pulse at cycle 0 -> src_req_valid at cycle 1.
  - Response at cycle k >= 2 -> wr_valid at k+1 when not back-pressured.
  - Minimum request-to-write latency: 3 cycles.

Test Plan:
1. dsm_base=0x1000, valid=1; req addr=0x41 (N_SRC=4 -> sel=1); src1 responds data 0xDEADBEEF_00000001 at cycle 3 -> src_req_valid=4'b0010 at cycle 1; wr_valid at cycle 4; wr_addr=0x1001; wr_data[63:0]=0xDEADBEEF_00000001, [95:64]=0, [111:96]=0x41, [127]=1, [126]=0.
2. Req addr=0xC0 with no response; SRC_TIMEOUT=255 -> wr_valid after timeout; data all-ones; [126]=1; src3 response 10 cycles later ignored; next request carries seq=1.
3. Request while dsm_base_valid=0 -> no src_req_valid, dropped_cnt=1. Second pulse while busy in WAIT -> dropped_cnt=2, in-flight request completes normally.
4. wr_almost_full held high 20 cycles during WRITE -> wr_valid=0 throughout, busy=1; deassert -> single wr_valid next cycle.
5. Response on src2 while sel=0 -> ignored. Response and timeout in the same cycle -> [126]=0 with captured data.
6. reset_n low during WAIT -> next cycle: IDLE, busy=0, seq=0, dropped_cnt=0; later response produces no wr_valid; fresh request succeeds with seq=0.
